// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA raster generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF      = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF      = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  localparam int POS_W   = 10;
  localparam int POS_MAX = 1 << POS_W;

  typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter plus sync/visible flags registered from
// the next count so they always line up with the presented position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int DISPLAY    = H_DISPLAY_DEF,
  parameter int SYNC_START = H_SYNC_START_DEF,
  parameter int SYNC_END   = H_SYNC_END_DEF,
  parameter bit SYNC_NEG   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output pos_t pos,
  output logic wrap,
  output logic sync,
  output logic visible
);

  pos_t pos_reg;
  pos_t pos_next;
  logic sync_reg;
  logic visible_reg;
  logic sync_active_next;
  logic visible_next;

  assign wrap = inc && (pos_reg == pos_t'(TOTAL - 1));

  always_comb begin
    pos_next = pos_reg;
    if (wrap) begin
      pos_next = '0;
    end else if (inc) begin
      pos_next = pos_reg + pos_t'(1);
    end
  end

  assign sync_active_next = (int'(pos_next) >= SYNC_START) && (int'(pos_next) < SYNC_END);
  assign visible_next     = int'(pos_next) < DISPLAY;

  // Reset parks the axis on its last position with sync at its idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_reg     <= pos_t'(TOTAL - 1);
      sync_reg    <= SYNC_NEG;
      visible_reg <= 1'b0;
    end else begin
      pos_reg     <= pos_next;
      sync_reg    <= sync_active_next ^ SYNC_NEG;
      visible_reg <= visible_next;
    end
  end

  assign pos     = pos_reg;
  assign sync    = sync_reg;
  assign visible = visible_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: sync pulses, position, visible-area flag,
// line/frame strobes and a free-running frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_NEG  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > POS_MAX || V_TOTAL > POS_MAX) begin : g_total_too_large
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit position range");
  end

  logic       h_wrap;
  logic       v_wrap;
  logic       h_visible;
  logic       v_visible;
  logic       line_start_reg;
  logic       frame_start_reg;
  logic [7:0] frame_cnt_reg;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .DISPLAY   (H_DISPLAY),
    .SYNC_START(H_DISPLAY + H_FRONT),
    .SYNC_END  (H_DISPLAY + H_FRONT + H_SYNC),
    .SYNC_NEG  (SYNC_NEG)
  ) u_h_axis (
    .clk    (clk),
    .reset  (reset),
    .inc    (1'b1),
    .pos    (hpos),
    .wrap   (h_wrap),
    .sync   (hsync),
    .visible(h_visible)
  );

  // The vertical axis only steps when the line wraps, so its wrap marks
  // the last pixel of the frame.
  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .DISPLAY   (V_DISPLAY),
    .SYNC_START(V_DISPLAY + V_FRONT),
    .SYNC_END  (V_DISPLAY + V_FRONT + V_SYNC),
    .SYNC_NEG  (SYNC_NEG)
  ) u_v_axis (
    .clk    (clk),
    .reset  (reset),
    .inc    (h_wrap),
    .pos    (vpos),
    .wrap   (v_wrap),
    .sync   (vsync),
    .visible(v_visible)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= 8'hFF;
    end else begin
      line_start_reg  <= h_wrap;
      frame_start_reg <= v_wrap;
      if (v_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  assign display_on  = h_visible && v_visible;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a behavioural raster model predicts every output of three
// instances (default timing, reduced timing, reduced timing with positive sync).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m, rst_s, rst_p;

  logic       m_hsync, m_vsync, m_disp, m_ls, m_fs;
  logic [9:0] m_hpos, m_vpos;
  logic [7:0] m_fc;
  logic       s_hsync, s_vsync, s_disp, s_ls, s_fs;
  logic [9:0] s_hpos, s_vpos;
  logic [7:0] s_fc;
  logic       p_hsync, p_vsync, p_disp, p_ls, p_fs;
  logic [9:0] p_hpos, p_vpos;
  logic [7:0] p_fc;

  vga_timing_gen u_main (
    .clk(clk), .reset(rst_m), .hsync(m_hsync), .vsync(m_vsync), .display_on(m_disp),
    .hpos(m_hpos), .vpos(m_vpos), .line_start(m_ls), .frame_start(m_fs), .frame_cnt(m_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_NEG(1'b1)
  ) u_small (
    .clk(clk), .reset(rst_s), .hsync(s_hsync), .vsync(s_vsync), .display_on(s_disp),
    .hpos(s_hpos), .vpos(s_vpos), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_NEG(1'b0)
  ) u_pol (
    .clk(clk), .reset(rst_p), .hsync(p_hsync), .vsync(p_vsync), .display_on(p_disp),
    .hpos(p_hpos), .vpos(p_vpos), .line_start(p_ls), .frame_start(p_fs), .frame_cnt(p_fc)
  );

  typedef struct {
    int          inst;
    logic [32:0] v;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int HD[3] = '{640, 4, 4};
  int HF[3] = '{16, 1, 1};
  int HS[3] = '{96, 2, 2};
  int HB[3] = '{48, 1, 1};
  int VD[3] = '{480, 3, 3};
  int VF[3] = '{10, 1, 1};
  int VS[3] = '{2, 1, 1};
  int VB[3] = '{33, 1, 1};
  bit NEG[3] = '{1'b1, 1'b1, 1'b0};
  int mh[3], mv[3], mfc[3];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected outputs derived directly from the raster definitions.
  function automatic logic [32:0] model_out(input int i);
    int  ht, vt;
    bit  hs_act, vs_act, disp;
    logic hs_lvl, vs_lvl;
    ht = HD[i] + HF[i] + HS[i] + HB[i];
    vt = VD[i] + VF[i] + VS[i] + VB[i];
    hs_act = (mh[i] >= HD[i] + HF[i]) && (mh[i] < HD[i] + HF[i] + HS[i]);
    vs_act = (mv[i] >= VD[i] + VF[i]) && (mv[i] < VD[i] + VF[i] + VS[i]);
    disp   = (mh[i] < HD[i]) && (mv[i] < VD[i]);
    hs_lvl = NEG[i] ? !hs_act : hs_act;
    vs_lvl = NEG[i] ? !vs_act : vs_act;
    if (ht > 1024 || vt > 1024) disp = 1'b0;
    return {hs_lvl, vs_lvl, disp, (mh[i] == 0), (mh[i] == 0 && mv[i] == 0),
            8'(mfc[i]), 10'(mh[i]), 10'(mv[i])};
  endfunction

  task automatic step_model(input int i, input bit r);
    int ht, vt;
    ht = HD[i] + HF[i] + HS[i] + HB[i];
    vt = VD[i] + VF[i] + VS[i] + VB[i];
    if (r) begin
      mh[i] = ht - 1; mv[i] = vt - 1; mfc[i] = 255;
    end else begin
      if (mh[i] == ht - 1) begin
        mh[i] = 0;
        mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
      end else begin
        mh[i] = mh[i] + 1;
      end
      if (mh[i] == 0 && mv[i] == 0) mfc[i] = (mfc[i] + 1) % 256;
    end
  endtask

  function automatic logic [32:0] dut_vec(input int i);
    case (i)
      0:       return {m_hsync, m_vsync, m_disp, m_ls, m_fs, m_fc, m_hpos, m_vpos};
      1:       return {s_hsync, s_vsync, s_disp, s_ls, s_fs, s_fc, s_hpos, s_vpos};
      default: return {p_hsync, p_vsync, p_disp, p_ls, p_fs, p_fc, p_hpos, p_vpos};
    endcase
  endfunction

  // One clock for all instances: drive resets, predict, then compare at negedge.
  task automatic tick(input bit r0, input bit r1, input bit r2);
    bit   r[3];
    exp_t e;
    string tags[3];
    tags = '{"cyc_main", "cyc_small", "cyc_pol"};
    r = '{r0, r1, r2};
    rst_m = r0; rst_s = r1; rst_p = r2;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      step_model(i, r[i]);
      e.inst = i;
      e.v    = model_out(i);
      sb.push_back(e);
    end
    @(negedge clk);
    cyc++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(tags[e.inst], dut_vec(e.inst), e.v);
      $display("[TB] cyc %0d inst %0d exp %h got %h", cyc, e.inst, e.v, dut_vec(e.inst));
    end
  endtask

  initial begin
    int hs_low, disp_fall, last_fs, wrap_seen;
    logic prev_disp;
    logic [7:0] prev_fc;
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0; mv[i] = 0; mfc[i] = 0;
    end
    rst_m = 1'b1; rst_s = 1'b1; rst_p = 1'b1;

    repeat (3) tick(1'b1, 1'b1, 1'b1);
    check_eq("rst_hpos", m_hpos, 799);
    check_eq("rst_vpos", m_vpos, 524);
    check_eq("rst_syncs", {m_hsync, m_vsync}, 2'b11);
    check_eq("rst_disp", m_disp, 0);
    check_eq("rst_fcnt", m_fc, 8'hFF);
    check_eq("pol_rst_syncs", {p_hsync, p_vsync}, 2'b00);

    tick(1'b0, 1'b0, 1'b0);
    check_eq("first_pos", {m_hpos, m_vpos}, 20'h0);
    check_eq("first_flags", {m_disp, m_ls, m_fs}, 3'b111);
    check_eq("first_fcnt", m_fc, 8'h00);

    hs_low = 0; disp_fall = -1; prev_disp = m_disp;
    repeat (799) begin
      tick(1'b0, 1'b0, 1'b0);
      if (!m_hsync) hs_low++;
      if (prev_disp && !m_disp && disp_fall < 0) disp_fall = int'(m_hpos);
      prev_disp = m_disp;
    end
    check_eq("hsync_width", hs_low, 96);
    check_eq("disp_fall_hpos", disp_fall, 640);

    tick(1'b0, 1'b0, 1'b0);
    check_eq("line_wrap", {m_hpos, m_vpos, m_ls, m_fs}, {10'd0, 10'd1, 1'b1, 1'b0});

    repeat (700) tick(1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_pos", {m_hpos, m_vpos, m_hsync}, {10'd700, 10'd1, 1'b0});
    tick(1'b1, 1'b0, 1'b0);
    check_eq("mid_rst_state", {m_hsync, m_hpos, m_vpos, m_fc}, {1'b1, 10'd799, 10'd524, 8'hFF});
    tick(1'b0, 1'b0, 1'b0);
    check_eq("restart", {m_hpos, m_vpos, m_fs, m_fc}, {10'd0, 10'd0, 1'b1, 8'h00});

    last_fs = -1; wrap_seen = 0; prev_fc = s_fc;
    repeat (48 * 260) begin
      tick(1'b0, 1'b0, 1'b0);
      if (s_fs) begin
        if (last_fs >= 0) check_eq("fs_period", cyc - last_fs, 48);
        last_fs = cyc;
        if (prev_fc == 8'hFF) begin
          check_eq("fc_wrap", s_fc, 8'h00);
          wrap_seen++;
        end
      end
      prev_fc = s_fc;
    end
    check_eq("wrap_seen", wrap_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the TinyVGA PMOD designs; sits directly upstream of the pixel-colour logic in each tt_um_vga_* top.
- Produces hsync/vsync, display_on and hpos/vpos, which the colour stage compares against to draw shapes.
- Adds line_start/frame_start strobes and a frame counter so downstream stages can animate without their own counters.
- Default is 640x480@60 at a 25 MHz pixel clock (one pixel per clk).

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_NEG, 1, 1 = sync pulses active-low, 0 = active-high

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, polarity per SYNC_NEG
- vsync  out  1  vertical sync, polarity per SYNC_NEG
- display_on  out  1  high while (hpos,vpos) is in the visible area
- hpos  out  10  current pixel column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when hpos==0
- frame_start  out  1  one-cycle pulse when hpos==0 and vpos==0
- frame_cnt  out  8  frame index, increments on every frame_start

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Both totals must be at most 1024; elaboration error otherwise.
- All outputs are registered. Within any cycle they are mutually consistent, i.e. every flag describes the hpos/vpos presented in that same cycle.
  - Implementation computes the flags from next-state counter values.
- hpos advances by 1 every clk and wraps from H_TOTAL-1 to 0.
- vpos advances by 1 only in the cycle where hpos wraps; vpos wraps from V_TOTAL-1 to 0.
- hsync active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751 by default).
- vsync active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491 by default).
  - vsync is not gated by hpos: it changes together with vpos at hpos==0.
- Active level is 0 when SYNC_NEG=1 and 1 otherwise.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- line_start = (hpos == 0); frame_start = (hpos == 0 && vpos == 0).
- frame_cnt increments modulo 256 in the same cycle frame_start is asserted, so it is stable for the whole frame.
- Reset state equals the steady state at the last pixel of frame 255:
  - hpos = H_TOTAL-1, vpos = V_TOTAL-1
  - hsync and vsync inactive, display_on = 0
  - line_start = 0, frame_start = 0, frame_cnt = 8'hFF
- First clk after reset deasserts: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1, frame_cnt=0.
- Reset asserted mid-frame: the reset state appears on the next clk edge; no partial sync pulse is stretched.
  - An hsync that was active drops on that edge.
- Reset held for multiple cycles: the reset state is held.
- Steady-state period: exactly H_TOTAL*V_TOTAL = 420000 clk between frame_start pulses.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480 timing constants
  - the derived H_TOTAL/V_TOTAL and sync start/end constants
  - a 10-bit position typedef
- One sub-module, vga_axis_counter, is instantiated twice (horizontal, then vertical) and provides:
  - a parameterised wrap counter with inc-enable and wrap output
  - registered sync and visible flags computed from its next value

Test Plan:
- Reset behaviour: hold reset 3 cycles, then release -> during reset hpos=799, vpos=524, hsync=vsync=1, display_on=0, frame_cnt=0xFF; first cycle after release hpos=0, vpos=0, frame_start=1, frame_cnt=0, display_on=1.
- Line timing: run one line -> display_on falls at hpos=640; hsync=0 exactly for hpos 656..751 (96 cycles); hpos 799->0 with vpos 0->1 and line_start=1.
- Frame timing: run a full frame -> vsync=0 for vpos 490..491 (1600 cycles); display_on never high for vpos>=480; next frame_start exactly 420000 cycles after the previous one, with frame_cnt=1.
- frame_cnt wrap: run 256 frames, or reduced parameters with H 4/1/2/1 and V 3/1/1/1 -> frame_cnt goes 255->0 on a frame_start; frame_start period equals 8*6=48 cycles.
- Reset mid-operation: assert reset at hpos=700, vpos=200 (inside hsync) -> next cycle reset state with hsync=1; after release the sequence restarts at (0,0) with frame_cnt=0.
- Polarity: SYNC_NEG=0 -> hsync/vsync idle at 0 and pulse high in the same windows; reset value of both is 0.
